// File: rtl/fpu_pkg.sv
// Shared types and constants for the parametrised FPU adder/subtractor.
// State encoding, status bit positions and the exponent bias helper.
package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ALIGN  = 3'd2,
    S_ADD    = 3'd3,
    S_NORM   = 3'd4,
    S_PACK   = 3'd5
  } state_e;

  localparam int ST_EXACT     = 0;
  localparam int ST_INEXACT   = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_OVERFLOW  = 3;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns N.
module fpu_lzc #(
  parameter  int N  = 26,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  data_i,
  output logic [CW-1:0] count_o
);

  logic found;

  always_comb begin
    count_o = CW'(N);
    found   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        count_o = CW'(N - 1 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_param.sv
// Multi-cycle floating-point add/subtract, truncating rounding, no denormals.
// Fixed 5-cycle latency: DECODE, ALIGN, ADD, NORM, PACK after the accept edge.
module fpu_addsub_param
  import fpu_pkg::*;
#(
  parameter  int EXP_W = 7,
  parameter  int MAN_W = 24,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out,
  output logic         busy,
  output logic         done,
  output state_e       state_dbg
);

  // Handshake: start is sampled only while IDLE (busy=0); done pulses for one
  // cycle with data_out/status_out valid, and those hold until the next done.

  localparam int MW = MAN_W + 1;   // mantissa with hidden bit
  localparam int SW = MAN_W + 2;   // sum with carry bit
  localparam int XW = EXP_W + 2;   // two's-complement working exponent
  localparam int CW = $clog2(SW + 1);

  state_e           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [W-1:0]     data_q, data_d;
  logic [3:0]       status_q, status_d;

  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d;
  logic             sgn_q, sgn_d, esub_q, esub_d;
  logic [EXP_W-1:0] exp_q, exp_d, diff_q, diff_d;
  logic [MW-1:0]    mbig_q, mbig_d, msml_q, msml_d, msh_q, msh_d;
  logic             sticky_q, sticky_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [MAN_W-1:0] man_q, man_d;
  logic [XW-1:0]    expn_q, expn_d;
  logic             zero_q, zero_d;

  // Unpacked operand fields; exponent zero means the value is zero.
  logic             sa, sb_eff, a_big;
  logic [EXP_W-1:0] ea, eb;
  logic [MW-1:0]    ma, mb;

  assign sa     = a_q[W-1];
  assign sb_eff = b_q[W-1] ^ sub_q;
  assign ea     = a_q[W-2 -: EXP_W];
  assign eb     = b_q[W-2 -: EXP_W];
  assign ma     = (ea != '0) ? {1'b1, a_q[MAN_W-1:0]} : '0;
  assign mb     = (eb != '0) ? {1'b1, b_q[MAN_W-1:0]} : '0;
  assign a_big  = {ea, ma} >= {eb, mb};

  // Shifting past the full width leaves zero in the upper half, all bits in sticky.
  logic [2*MW-1:0] ext;
  assign ext = {msml_q, {MW{1'b0}}} >> diff_q;

  logic [SW-1:0] sum_w;
  assign sum_w = esub_q ? ({1'b0, mbig_q} - {1'b0, msh_q})
                        : ({1'b0, mbig_q} + {1'b0, msh_q});

  logic [CW-1:0] lzc, shl;
  logic          carry;
  logic [XW-1:0] exp_ext;

  fpu_lzc #(.N(SW)) u_lzc (
    .data_i  (sum_q),
    .count_o (lzc)
  );

  // Bit SW-1 is zero when not carrying, so the hidden-bit shift is lzc-1.
  assign shl     = lzc - CW'(1);
  assign carry   = sum_q[SW-1];
  assign exp_ext = {{(XW - EXP_W){1'b0}}, exp_q};

  logic ovf, unf;
  assign ovf = !expn_q[XW-1] && expn_q[EXP_W];
  assign unf = expn_q[XW-1] || (expn_q == '0);

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    data_d   = data_q;
    status_d = status_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    sgn_d    = sgn_q;
    esub_d   = esub_q;
    exp_d    = exp_q;
    diff_d   = diff_q;
    mbig_d   = mbig_q;
    msml_d   = msml_q;
    msh_d    = msh_q;
    sticky_d = sticky_q;
    sum_d    = sum_q;
    man_d    = man_q;
    expn_d   = expn_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_A_in;
          b_d     = op_B_in;
          sub_d   = op_sub;
          busy_d  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        esub_d  = sa ^ sb_eff;
        sgn_d   = a_big ? sa : sb_eff;
        exp_d   = a_big ? ea : eb;
        diff_d  = a_big ? (ea - eb) : (eb - ea);
        mbig_d  = a_big ? ma : mb;
        msml_d  = a_big ? mb : ma;
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
        msh_d    = ext[2*MW-1:MW];
        sticky_d = |ext[MW-1:0];
        state_d  = S_ADD;
      end
      S_ADD: begin
        sum_d   = sum_w;
        state_d = S_NORM;
      end
      S_NORM: begin
        zero_d = (sum_q == '0);
        if (carry) begin
          man_d    = sum_q[MAN_W:1];
          expn_d   = exp_ext + XW'(1);
          sticky_d = sticky_q | sum_q[0];
        end else begin
          man_d  = MAN_W'(sum_q << shl);
          expn_d = exp_ext - XW'(shl);
        end
        state_d = S_PACK;
      end
      S_PACK: begin
        status_d = '0;
        if (zero_q) begin
          data_d             = '0;
          status_d[ST_EXACT] = 1'b1;
        end else if (ovf) begin
          data_d                = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          status_d[ST_OVERFLOW] = 1'b1;
          status_d[ST_INEXACT]  = 1'b1;
        end else if (unf) begin
          data_d                 = '0;
          status_d[ST_UNDERFLOW] = 1'b1;
          status_d[ST_INEXACT]   = 1'b1;
        end else begin
          data_d = {sgn_q, expn_q[EXP_W-1:0], man_q};
          if (sticky_q) status_d[ST_INEXACT] = 1'b1;
          else          status_d[ST_EXACT]   = 1'b1;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  // Datapath registers carry no reset; they are always written before use.
  always_ff @(posedge clock) begin
    a_q      <= a_d;
    b_q      <= b_d;
    sub_q    <= sub_d;
    sgn_q    <= sgn_d;
    esub_q   <= esub_d;
    exp_q    <= exp_d;
    diff_q   <= diff_d;
    mbig_q   <= mbig_d;
    msml_q   <= msml_d;
    msh_q    <= msh_d;
    sticky_q <= sticky_d;
    sum_q    <= sum_d;
    man_q    <= man_d;
    expn_q   <= expn_d;
    zero_q   <= zero_d;
  end

  assign data_out   = data_q;
  assign status_out = status_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Directed bench for fpu_addsub_param at default parameters (bias 63).
// Expected {data, status} and accept cycle are queued at issue; a monitor checks on done.
module tb_fpu_addsub_param;
  import fpu_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] op_A_in = '0;
  logic [W-1:0] op_B_in = '0;
  logic [W-1:0] data_out;
  logic [3:0]   status_out;
  logic         busy;
  logic         done;
  state_e       state_dbg;

  fpu_addsub_param dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op_sub     (op_sub),
    .op_A_in    (op_A_in),
    .op_B_in    (op_B_in),
    .data_out   (data_out),
    .status_out (status_out),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- scoreboard ----------------
  logic [W+3:0] exp_q[$];
  int           acc_q[$];
  int           total = 0;
  int           bad = 0;

  task automatic check(input string name, input logic [W+3:0] act, input logic [W+3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got data=%h status=%b want no done", data_out, status_out);
      end else begin
        logic [W+3:0] e;
        int           a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("result", {data_out, status_out}, e);
        check("latency", 36'(cyc - a), 36'(5));
        check("busy_low_in_done", 36'(busy), 36'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 want busy=0 within 50 cycles");
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] exp_d, input logic [3:0] exp_s);
    wait_idle();
    op_A_in = a;
    op_B_in = b;
    op_sub  = sub;
    start   = 1'b1;
    exp_q.push_back({exp_d, exp_s});
    acc_q.push_back(cyc + 1);
    @(negedge clock);
    start = 1'b0;
    check("busy_after_accept", 36'(busy), 36'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_data", {data_out, status_out}, '0);
    check("reset_ctrl", {34'(0), busy, done}, '0);
    check("reset_state", 36'(state_dbg), 36'(S_IDLE));
    reset = 1'b0;

    // Reset during ALIGN abandons the operation: no done, outputs stay zero.
    @(negedge clock);
    op_A_in = 32'h40000000;
    op_B_in = 32'h3F800000;
    op_sub  = 1'b0;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("midop_in_align", 36'(state_dbg), 36'(S_ALIGN));
    reset = 1'b1;
    @(negedge clock);
    check("midop_reset_state", 36'(state_dbg), 36'(S_IDLE));
    check("midop_reset_ctrl", {34'(0), busy, done}, '0);
    check("midop_reset_data", {data_out, status_out}, '0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("midop_no_result", {data_out, status_out}, '0);

    // Directed vectors: {A, B, op_sub} -> {data, status}.
    issue(32'h40000000, 32'h3F800000, 1'b0, 32'h40C00000, 4'b0001); // 2.0 + 1.5
    issue(32'h40000000, 32'h3F800000, 1'b1, 32'h3E000000, 4'b0001); // 2.0 - 1.5
    issue(32'h40000000, 32'hBF800000, 1'b0, 32'h3E000000, 4'b0001); // 2.0 + -1.5
    issue(32'h3F800000, 32'h40000000, 1'b1, 32'hBE000000, 4'b0001); // 1.5 - 2.0
    issue(32'hBF800000, 32'h40000000, 1'b1, 32'hC0C00000, 4'b0001); // -1.5 - 2.0
    issue(32'h3F000000, 32'h3F000000, 1'b1, 32'h00000000, 4'b0001); // x - x
    issue(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0001); // 0 + 0
    issue(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h7F000000, 4'b1010); // overflow
    issue(32'h7F000000, 32'h7F000000, 1'b0, 32'h7F000000, 4'b1010); // overflow, no lost bits
    issue(32'h7E000000, 32'h7E000000, 1'b0, 32'h7F000000, 4'b0001); // top normal exponent
    issue(32'h01000001, 32'h01000000, 1'b1, 32'h00000000, 4'b0110); // underflow
    issue(32'h01800000, 32'h01000000, 1'b1, 32'h00000000, 4'b0110); // lands on exp 0
    issue(32'h02000000, 32'h01000000, 1'b1, 32'h01000000, 4'b0001); // min normal
    issue(32'h3F000000, 32'h3E000001, 1'b0, 32'h3F800000, 4'b0010); // bit shifted out
    issue(32'h3F000000, 32'h21000000, 1'b0, 32'h3F000000, 4'b0010); // 1.0 + 2^-30

    // Start held high across a whole operation and its done cycle.
    wait_idle();
    op_A_in = 32'h3F000000;
    op_B_in = 32'h21000000;
    op_sub  = 1'b0;
    start   = 1'b1;
    exp_q.push_back({32'h3F000000, 4'b0010});
    acc_q.push_back(cyc + 1);
    @(negedge clock);
    op_A_in = 32'h40000000;
    op_B_in = 32'h3F800000;
    op_sub  = 1'b1;
    exp_q.push_back({32'h3E000000, 4'b0001});
    acc_q.push_back(cyc + 6);
    check("b2b_busy_0", 36'(busy), 36'(1));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      check("b2b_busy_mid", 36'(busy), 36'(1));
    end
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    check("b2b_second_accepted", 36'(busy), 36'(1));

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (10) @(negedge clock);
    check("queue_drained", 36'(exp_q.size()), 36'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
